// File: rtl/vx_ifetch_pkg.sv
// Shared types for the instruction-fetch request path: request payload,
// skid-buffer states and the channel-index width helper.
package vx_ifetch_pkg;

  localparam int unsigned IF_NUM_THREADS = 4;
  localparam int unsigned IF_NW_BITS     = 2;
  localparam int unsigned IF_UUID_BITS   = 44;
  localparam int unsigned IF_PC_BITS     = 32;

  typedef struct packed {
    logic [IF_UUID_BITS-1:0]   uuid;
    logic [IF_NUM_THREADS-1:0] tmask;
    logic [IF_NW_BITS-1:0]     wid;
    logic [IF_PC_BITS-1:0]     PC;
  } ifetch_req_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned req_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_ifetch_skid_buf.sv
// Two-entry elastic buffer: registers the output and decouples the upstream
// ready from out_ready so the accept path only sees local state.
module vx_ifetch_skid_buf
  import vx_ifetch_pkg::*;
#(
  parameter int unsigned DATAW = $bits(ifetch_req_t) + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready_c,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);

  skid_state_e      state_q, state_d;
  logic [DATAW-1:0] main_q, skid_q;
  logic             load_main, load_skid, main_from_skid;
  logic             fire;

  assign in_ready_c = (state_q != SKID_FULL);
  assign fire       = in_valid && in_ready_c;
  assign out_valid  = (state_q != SKID_EMPTY);
  assign out_data   = main_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SKID_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (fire) begin
          state_d   = SKID_ONE;
          load_main = 1'b1;
        end
      end
      SKID_ONE: begin
        if (fire && out_ready) begin
          load_main = 1'b1;
        end else if (fire) begin
          state_d   = SKID_FULL;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_ready) begin
          state_d        = SKID_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Main drives the output; skid only catches the request accepted during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/vx_ifetch_req_arb.sv
// Round-robin arbiter merging per-warp-scheduler ifetch requests into one
// icache request stream, optionally through a skid buffer.
module vx_ifetch_req_arb
  import vx_ifetch_pkg::*;
#(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned NUM_THREADS = IF_NUM_THREADS,
  parameter int unsigned NW_BITS     = IF_NW_BITS,
  parameter int unsigned UUID_BITS   = IF_UUID_BITS,
  parameter int unsigned PC_BITS     = IF_PC_BITS,
  parameter int unsigned BUFFERED    = 1,
  localparam int unsigned REQ_BITS   = req_bits(NUM_REQS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             in_valid,
  input  logic [NUM_REQS*UUID_BITS-1:0]   in_uuid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_REQS*NW_BITS-1:0]     in_wid,
  input  logic [NUM_REQS*PC_BITS-1:0]     in_PC,
  output logic [NUM_REQS-1:0]             in_ready,
  output logic                            out_valid,
  output logic [UUID_BITS-1:0]            out_uuid,
  output logic [NUM_THREADS-1:0]          out_tmask,
  output logic [NW_BITS-1:0]              out_wid,
  output logic [PC_BITS-1:0]              out_PC,
  output logic [REQ_BITS-1:0]             out_idx,
  input  logic                            out_ready,
  output logic [31:0]                     perf_stalls
);

  logic [REQ_BITS-1:0] rr_ptr, grant, rr_next;
  logic                grant_valid;
  logic                accept;
  logic                in_fire;
  logic [31:0]         perf_q;
  ifetch_req_t         sel_req;

  // First valid channel at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned         sum;
    logic [REQ_BITS-1:0] cand;
    grant       = '0;
    grant_valid = 1'b0;
    sum         = 0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      sum  = 32'(rr_ptr) + i;
      cand = REQ_BITS'(sum % NUM_REQS);
      if (!grant_valid && in_valid[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    sel_req.uuid  = in_uuid[32'(grant)*UUID_BITS +: UUID_BITS];
    sel_req.tmask = in_tmask[32'(grant)*NUM_THREADS +: NUM_THREADS];
    sel_req.wid   = in_wid[32'(grant)*NW_BITS +: NW_BITS];
    sel_req.PC    = in_PC[32'(grant)*PC_BITS +: PC_BITS];
  end

  assign in_fire = grant_valid && accept && !reset;

  always_comb begin
    in_ready = '0;
    if (in_fire) in_ready[grant] = 1'b1;
  end

  assign rr_next = (32'(grant) == NUM_REQS - 1) ? '0 : grant + REQ_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rr_ptr <= '0;
    else if (in_fire) rr_ptr <= rr_next;
  end

  if (BUFFERED != 0) begin : g_buf
    localparam int unsigned SKID_W = $bits(ifetch_req_t) + REQ_BITS;
    logic [SKID_W-1:0] skid_out;
    ifetch_req_t       out_req;

    vx_ifetch_skid_buf #(.DATAW(SKID_W)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (grant_valid && !reset),
      .in_data    ({sel_req, grant}),
      .in_ready_c (accept),
      .out_valid  (out_valid),
      .out_data   (skid_out),
      .out_ready  (out_ready)
    );

    assign {out_req, out_idx} = skid_out;
    assign out_uuid  = out_req.uuid;
    assign out_tmask = out_req.tmask;
    assign out_wid   = out_req.wid;
    assign out_PC    = out_req.PC;
  end else begin : g_comb
    assign accept    = out_ready;
    assign out_valid = grant_valid && !reset;
    assign out_idx   = grant;
    assign out_uuid  = sel_req.uuid;
    assign out_tmask = sel_req.tmask;
    assign out_wid   = sel_req.wid;
    assign out_PC    = sel_req.PC;
  end

  // Saturating count of cycles the icache is holding us off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        perf_q <= '0;
    else if (out_valid && !out_ready && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_ifetch_req_arb.sv
// Directed bench for vx_ifetch_req_arb: buffered instance for arbitration,
// backpressure, saturation and reset; pass-through instance for zero latency.
module tb_vx_ifetch_req_arb;

  logic         clk = 1'b0;
  logic         reset;

  logic [3:0]   in_valid, in_ready;
  logic [175:0] in_uuid;
  logic [15:0]  in_tmask;
  logic [7:0]   in_wid;
  logic [127:0] in_PC;
  logic         out_valid, out_ready;
  logic [43:0]  out_uuid;
  logic [3:0]   out_tmask;
  logic [1:0]   out_wid, out_idx;
  logic [31:0]  out_PC, perf_stalls;

  logic [3:0]   c_in_valid, c_in_ready;
  logic [175:0] c_in_uuid;
  logic [15:0]  c_in_tmask;
  logic [7:0]   c_in_wid;
  logic [127:0] c_in_PC;
  logic         c_out_valid, c_out_ready;
  logic [43:0]  c_out_uuid;
  logic [3:0]   c_out_tmask;
  logic [1:0]   c_out_wid, c_out_idx;
  logic [31:0]  c_out_PC, c_perf_stalls;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vx_ifetch_req_arb #(.BUFFERED(1)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_uuid(in_uuid), .in_tmask(in_tmask),
    .in_wid(in_wid), .in_PC(in_PC), .in_ready(in_ready),
    .out_valid(out_valid), .out_uuid(out_uuid), .out_tmask(out_tmask),
    .out_wid(out_wid), .out_PC(out_PC), .out_idx(out_idx),
    .out_ready(out_ready), .perf_stalls(perf_stalls)
  );

  vx_ifetch_req_arb #(.BUFFERED(0)) u_comb (
    .clk(clk), .reset(reset),
    .in_valid(c_in_valid), .in_uuid(c_in_uuid), .in_tmask(c_in_tmask),
    .in_wid(c_in_wid), .in_PC(c_in_PC), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_uuid(c_out_uuid), .out_tmask(c_out_tmask),
    .out_wid(c_out_wid), .out_PC(c_out_PC), .out_idx(c_out_idx),
    .out_ready(c_out_ready), .perf_stalls(c_perf_stalls)
  );

  function automatic logic [31:0] pc_of(input int ch);
    return 32'h1000_0000 + 32'(ch) * 32'h100;
  endfunction

  task automatic set_chan(input int ch, input logic [31:0] pc);
    in_PC[ch*32 +: 32]   = pc;
    in_uuid[ch*44 +: 44] = {12'hA5, pc};
    in_tmask[ch*4 +: 4]  = 4'b0001 << ch;
    in_wid[ch*2 +: 2]    = 2'(ch);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = '0; in_uuid = '0; in_tmask = '0; in_wid = '0; in_PC = '0;
    out_ready = 1'b1;
    c_in_valid = '0; c_in_uuid = '0; c_in_tmask = '0; c_in_wid = '0; c_in_PC = '0;
    c_out_ready = 1'b1;
    for (int ch = 0; ch < 4; ch++) set_chan(ch, pc_of(ch));
    tick(); tick();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (perf_stalls !== 32'd0) begin failures++; $display("FAIL reset_perf got=%h exp=0", perf_stalls); end
    checks++;
    if (out_PC !== 32'd0) begin failures++; $display("FAIL reset_payload got=%h exp=0", out_PC); end
    checks++;
    in_valid = 4'b1111;
    #1;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    checks++;
    in_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (in_ready !== (4'b0001 << (k % 4))) begin
        failures++; $display("FAIL fair_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << (k % 4));
      end
      checks++;
      tick();
      if (out_valid !== 1'b1 || out_idx !== 2'(k % 4) || out_PC !== pc_of(k % 4)) begin
        failures++;
        $display("FAIL fair_out[%0d] got v=%b idx=%0d pc=%h exp v=1 idx=%0d pc=%h",
                 k, out_valid, out_idx, out_PC, k % 4, pc_of(k % 4));
      end
      checks++;
      if (out_uuid !== {12'hA5, pc_of(k % 4)} || out_wid !== 2'(k % 4) ||
          out_tmask !== (4'b0001 << (k % 4))) begin
        failures++;
        $display("FAIL fair_fields[%0d] got uuid=%h wid=%0d tmask=%b", k, out_uuid, out_wid, out_tmask);
      end
      checks++;
    end
    in_valid = '0;
    tick();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fair_drain got=%b exp=0", out_valid); end
    checks++;
  endtask

  task automatic test_sparse();
    logic [1:0] exp_idx [4];
    exp_idx[0] = 2'd3; exp_idx[1] = 2'd2; exp_idx[2] = 2'd3; exp_idx[3] = 2'd2;
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (in_ready !== (4'b0001 << exp_idx[k])) begin
        failures++; $display("FAIL sparse_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << exp_idx[k]);
      end
      checks++;
      tick();
      if (out_idx !== exp_idx[k] || out_PC !== pc_of(int'(exp_idx[k]))) begin
        failures++; $display("FAIL sparse_order[%0d] got idx=%0d pc=%h exp idx=%0d", k, out_idx, out_PC, exp_idx[k]);
      end
      checks++;
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = 32'h2000_0000;
    set_chan(1, a);
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    #1;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready got=%b exp=0010", in_ready); end
    checks++;
    tick();
    set_chan(1, a + 32'd4);
    #1;
    if (out_valid !== 1'b1 || out_PC !== a || in_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_one got v=%b pc=%h rdy=%b exp v=1 pc=%h rdy=0010", out_valid, out_PC, in_ready, a);
    end
    checks++;
    tick();
    set_chan(1, a + 32'd8);
    #1;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_full_ready got=%b exp=0000", in_ready); end
    checks++;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_PC !== a || out_idx !== 2'd1 || in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b pc=%h idx=%0d rdy=%b", k, out_valid, out_PC, out_idx, in_ready);
      end
      checks++;
    end
    if (perf_stalls !== 32'd5) begin failures++; $display("FAIL bp_perf got=%0d exp=5", perf_stalls); end
    checks++;
    out_ready = 1'b1;
    #1;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_comb_ready got=%b exp=0000", in_ready); end
    checks++;
    tick();
    if (out_PC !== a + 32'd4) begin failures++; $display("FAIL bp_drain1 got=%h exp=%h", out_PC, a + 32'd4); end
    checks++;
    #1;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_reopen got=%b exp=0010", in_ready); end
    checks++;
    tick();
    set_chan(1, a + 32'd12);
    in_valid = '0;
    if (out_PC !== a + 32'd8 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_drain2 got v=%b pc=%h exp v=1 pc=%h", out_valid, out_PC, a + 32'd8);
    end
    checks++;
    tick();
    if (out_valid !== 1'b0 || perf_stalls !== 32'd5) begin
      failures++; $display("FAIL bp_empty got v=%b perf=%0d exp v=0 perf=5", out_valid, perf_stalls);
    end
    checks++;
  endtask

  task automatic test_saturation();
    force u_dut.perf_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.perf_q;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    if (perf_stalls !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffffffe", perf_stalls); end
    checks++;
    tick();
    if (perf_stalls !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffffffff", perf_stalls); end
    checks++;
    tick(); tick();
    if (perf_stalls !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffffffff", perf_stalls); end
    checks++;
  endtask

  task automatic test_reset_midfull();
    #1;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_pre_full got rdy=%b v=%b exp rdy=0000 v=1", in_ready, out_valid);
    end
    checks++;
    reset = 1'b1;
    #1;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || perf_stalls !== 32'd0 || out_PC !== 32'd0) begin
      failures++; $display("FAIL rst_mid got v=%b rdy=%b perf=%h pc=%h", out_valid, in_ready, perf_stalls, out_PC);
    end
    checks++;
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    if (out_valid !== 1'b0 || in_ready !== 4'b0001) begin
      failures++; $display("FAIL rst_release got v=%b rdy=%b exp v=0 rdy=0001", out_valid, in_ready);
    end
    checks++;
    tick();
    if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_PC !== pc_of(0)) begin
      failures++; $display("FAIL rst_first got v=%b idx=%0d pc=%h exp v=1 idx=0 pc=%h", out_valid, out_idx, out_PC, pc_of(0));
    end
    checks++;
    in_valid = '0;
    tick();
  endtask

  task automatic test_unbuffered();
    c_in_PC[31:0]   = 32'h8000_0000;
    c_in_PC[95:64]  = 32'h8000_0200;
    c_in_valid  = 4'b0001;
    c_out_ready = 1'b1;
    #1;
    if (c_out_valid !== 1'b1 || c_out_PC !== 32'h8000_0000 || c_in_ready !== 4'b0001 || c_out_idx !== 2'd0) begin
      failures++; $display("FAIL comb_pass got v=%b pc=%h rdy=%b idx=%0d", c_out_valid, c_out_PC, c_in_ready, c_out_idx);
    end
    checks++;
    tick();
    c_in_valid = 4'b0101;
    #1;
    if (c_out_idx !== 2'd2 || c_out_PC !== 32'h8000_0200 || c_in_ready !== 4'b0100) begin
      failures++; $display("FAIL comb_rr got idx=%0d pc=%h rdy=%b exp idx=2 pc=80000200 rdy=0100", c_out_idx, c_out_PC, c_in_ready);
    end
    checks++;
    c_out_ready = 1'b0;
    #1;
    if (c_in_ready !== 4'b0000 || c_out_valid !== 1'b1) begin
      failures++; $display("FAIL comb_stall_ready got rdy=%b v=%b exp rdy=0000 v=1", c_in_ready, c_out_valid);
    end
    checks++;
    tick();
    if (c_perf_stalls !== 32'd1) begin failures++; $display("FAIL comb_perf got=%0d exp=1", c_perf_stalls); end
    checks++;
    c_in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_sparse();
    test_backpressure();
    test_saturation();
    test_reset_midfull();
    test_unbuffered();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
